// File: rtl/cpu_ctrl_pkg.sv
// Shared decode/control types for the CPU front end: class codes and the control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    // Two-bit instruction class carried in the top bits of the opcode
    typedef enum logic [1:0] {
        CLS_LDA = 2'b00,
        CLS_STA = 2'b01,
        CLS_IMM = 2'b10,
        CLS_BAF = 2'b11
    } cls_e;

    // Control bundle handed from decode to execute
    typedef struct packed {
        logic branch;
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
        logic immediate;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Squash counter width; the window length is limited to 0..7
    localparam int SQ_CNT_W = 3;

endpackage

// File: rtl/opcode_class_decode.sv
// Maps an instruction class to its control bundle.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup with no state.
module opcode_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] cls_dat,
    output ctrl_t      ctrl_dat
);

    // Class lookup; every bit not named for a class stays low
    always_comb begin
        ctrl_dat = CTRL_NOP;
        case (cls_dat)
            CLS_LDA: begin
                ctrl_dat.reg_write  = 1'b1;
                ctrl_dat.mem_read   = 1'b1;
                ctrl_dat.mem_to_reg = 1'b1;
            end
            CLS_STA: ctrl_dat.mem_write = 1'b1;
            CLS_IMM: begin
                ctrl_dat.reg_write = 1'b1;
                ctrl_dat.immediate = 1'b1;
            end
            default: ctrl_dat.branch = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// ID/EX decode stage: classifies opcodes, registers control + register addresses, squashes after branches.
// Latency: 1 cycle from accept to o_valid; o_flush pulses in the branch's first o_valid cycle.
// Backpressure: holds when o_valid && !i_ex_ready; inserts one bubble on load-use (o_ready low).
module decode_ctrl_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int FUNC_W   = 2,
    parameter int REG_W    = 3,
    parameter int SQUASH_N = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [OP_W-1:0]   i_opcode,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [REG_W-1:0]  i_rs,
    input  logic              i_ex_ready,
    input  logic              i_flush,
    output logic              o_valid,
    output logic              o_branch,
    output logic              o_reg_write,
    output logic              o_mem_write,
    output logic              o_mem_read,
    output logic              o_mem_to_reg,
    output logic              o_immediate,
    output logic [FUNC_W-1:0] o_alufunc,
    output logic [REG_W-1:0]  o_rd,
    output logic [REG_W-1:0]  o_rs,
    output logic              o_flush
);

    localparam logic [SQ_CNT_W-1:0] SQ_LOAD = SQ_CNT_W'(SQUASH_N);
    localparam logic [SQ_CNT_W-1:0] SQ_ONE  = SQ_CNT_W'(1);

    typedef enum logic {
        ST_RUN,
        ST_SQUASH
    } state_e;

    state_e              state;
    logic [SQ_CNT_W-1:0] sq_cnt;
    logic                out_vld;
    ctrl_t               ctrl_q;
    ctrl_t               dec_ctrl;
    logic [FUNC_W-1:0]   alufunc_q;
    logic [REG_W-1:0]    rd_q;
    logic [REG_W-1:0]    rs_q;
    logic                flush_q;

    logic                advance;
    logic                hazard;
    logic                in_rdy;
    logic                accept;
    logic                squash_act;

    opcode_class_decode u_class_decode (
        .cls_dat  (i_opcode[OP_W-1 -: 2]),
        .ctrl_dat (dec_ctrl)
    );

    // Handshake and load-use detection; the squash window masks the hazard because those slots are dropped anyway
    always_comb begin
        squash_act = (state == ST_SQUASH);
        advance    = !out_vld || i_ex_ready;
        hazard     = out_vld && ctrl_q.mem_read && i_valid && (rd_q == i_rs) && !squash_act;
        in_rdy     = i_rst_n && advance && !hazard;
        accept     = i_valid && in_rdy;
    end

    // Pipeline register and RUN/SQUASH control; o_flush clears on any non-loading cycle so it never stretches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_RUN;
            sq_cnt    <= '0;
            out_vld   <= 1'b0;
            ctrl_q    <= CTRL_NOP;
            alufunc_q <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            flush_q   <= 1'b0;
        end else if (i_flush) begin
            state   <= ST_RUN;
            sq_cnt  <= '0;
            out_vld <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            flush_q <= 1'b0;
        end else if (advance) begin
            if (accept && !squash_act) begin
                out_vld   <= 1'b1;
                ctrl_q    <= dec_ctrl;
                alufunc_q <= i_opcode[FUNC_W-1:0];
                rd_q      <= i_rd;
                rs_q      <= i_rs;
                flush_q   <= dec_ctrl.branch;
                if (dec_ctrl.branch && (SQ_LOAD != '0)) begin
                    state  <= ST_SQUASH;
                    sq_cnt <= SQ_LOAD;
                end
            end else begin
                // Bubble: hazard stall, idle fetch, or an instruction dropped inside the window
                out_vld <= 1'b0;
                ctrl_q  <= CTRL_NOP;
                flush_q <= 1'b0;
                if (accept) begin
                    sq_cnt <= sq_cnt - SQ_ONE;
                    if (sq_cnt == SQ_ONE) begin
                        state <= ST_RUN;
                    end
                end
            end
        end else begin
            flush_q <= 1'b0;
        end
    end

    // Output mapping
    always_comb begin
        o_ready      = in_rdy;
        o_valid      = out_vld;
        o_branch     = ctrl_q.branch;
        o_reg_write  = ctrl_q.reg_write;
        o_mem_write  = ctrl_q.mem_write;
        o_mem_read   = ctrl_q.mem_read;
        o_mem_to_reg = ctrl_q.mem_to_reg;
        o_immediate  = ctrl_q.immediate;
        o_alufunc    = alufunc_q;
        o_rd         = rd_q;
        o_rs         = rs_q;
        o_flush      = flush_q;
    end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: vector table plus hand sequences for reset corners, scoreboard-checked.
// Latency: expects registered outputs one cycle after each applied vector.
// Backpressure: drives i_ex_ready low in selected vectors and expects o_ready low / held outputs.
module tb_decode_ctrl_stage;

    localparam int OP_W     = 4;
    localparam int FUNC_W   = 2;
    localparam int REG_W    = 3;
    localparam int SQUASH_N = 2;

    // Control bundle order: {branch, reg_write, mem_write, mem_read, mem_to_reg, immediate}
    localparam logic [5:0] C_LDA = 6'b010110;
    localparam logic [5:0] C_STA = 6'b001000;
    localparam logic [5:0] C_IMM = 6'b010001;
    localparam logic [5:0] C_BAF = 6'b100000;
    localparam logic [5:0] C_NOP = 6'b000000;

    typedef struct packed {
        logic       vld;
        logic [5:0] ctl;
        logic [1:0] alu;
        logic [2:0] rd;
        logic [2:0] rs;
        logic       fl;
    } exp_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic       exr;
        logic       fl;
        logic       rdy;
        exp_t       exp;
    } vec_t;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_valid;
    logic              o_ready;
    logic [OP_W-1:0]   i_opcode;
    logic [REG_W-1:0]  i_rd;
    logic [REG_W-1:0]  i_rs;
    logic              i_ex_ready;
    logic              i_flush;
    logic              o_valid;
    logic              o_branch;
    logic              o_reg_write;
    logic              o_mem_write;
    logic              o_mem_read;
    logic              o_mem_to_reg;
    logic              o_immediate;
    logic [FUNC_W-1:0] o_alufunc;
    logic [REG_W-1:0]  o_rd;
    logic [REG_W-1:0]  o_rs;
    logic              o_flush;

    exp_t sb_q[$];
    vec_t tbl[24];
    int   n_cmp = 0;
    int   n_err = 0;

    decode_ctrl_stage #(
        .OP_W     (OP_W),
        .FUNC_W   (FUNC_W),
        .REG_W    (REG_W),
        .SQUASH_N (SQUASH_N)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_opcode     (i_opcode),
        .i_rd         (i_rd),
        .i_rs         (i_rs),
        .i_ex_ready   (i_ex_ready),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .o_branch     (o_branch),
        .o_reg_write  (o_reg_write),
        .o_mem_write  (o_mem_write),
        .o_mem_read   (o_mem_read),
        .o_mem_to_reg (o_mem_to_reg),
        .o_immediate  (o_immediate),
        .o_alufunc    (o_alufunc),
        .o_rd         (o_rd),
        .o_rs         (o_rs),
        .o_flush      (o_flush)
    );

    always #5 i_clk = ~i_clk;

    function automatic vec_t mk(input logic vld, input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                                input logic exr, input logic fl, input logic rdy,
                                input logic ev, input logic [5:0] ctl, input logic [1:0] alu,
                                input logic [2:0] erd, input logic [2:0] ers, input logic ef);
        vec_t v;
        v.vld     = vld;
        v.op      = op;
        v.rd      = rd;
        v.rs      = rs;
        v.exr     = exr;
        v.fl      = fl;
        v.rdy     = rdy;
        v.exp.vld = ev;
        v.exp.ctl = ctl;
        v.exp.alu = alu;
        v.exp.rd  = erd;
        v.exp.rs  = ers;
        v.exp.fl  = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {o_valid, o_branch, o_reg_write, o_mem_write, o_mem_read, o_mem_to_reg, o_immediate,
                o_alufunc, o_rd, o_rs, o_flush};
    endfunction

    // Drive one cycle, check o_ready before the edge, check registered outputs after it via the scoreboard
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        @(negedge i_clk);
        i_valid    = v.vld;
        i_opcode   = v.op;
        i_rd       = v.rd;
        i_rs       = v.rs;
        i_ex_ready = v.exr;
        i_flush    = v.fl;
        #1;
        check({tag, " ready"}, 32'(o_ready), 32'(v.rdy));
        sb_q.push_back(v.exp);
        @(posedge i_clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, " valid"}, 32'(o_valid), 32'(e.vld));
            check({tag, " flush"}, 32'(o_flush), 32'(e.fl));
            if (e.vld) begin
                check({tag, " ctrl"}, 32'({o_branch, o_reg_write, o_mem_write, o_mem_read, o_mem_to_reg, o_immediate}),
                      32'(e.ctl));
                check({tag, " alufunc"}, 32'(o_alufunc), 32'(e.alu));
                check({tag, " rd"}, 32'(o_rd), 32'(e.rd));
                check({tag, " rs"}, 32'(o_rs), 32'(e.rs));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            vld op       rd rs exr fl rdy   ev ctl    alu   rd rs fl
        tbl[0]  = mk(1, 4'b1001, 2, 0, 1, 0, 1,    1, C_IMM, 2'b01, 2, 0, 0);  // basic IMM
        tbl[1]  = mk(1, 4'b0010, 3, 1, 1, 0, 1,    1, C_LDA, 2'b10, 3, 1, 0);  // load r3
        tbl[2]  = mk(1, 4'b0111, 0, 3, 1, 0, 0,    0, C_NOP, 2'b00, 0, 0, 0);  // STA uses r3: stall
        tbl[3]  = mk(1, 4'b0111, 0, 3, 1, 0, 1,    1, C_STA, 2'b11, 0, 3, 0);  // STA issues after bubble
        tbl[4]  = mk(0, 4'b0000, 0, 0, 1, 0, 1,    0, C_NOP, 2'b00, 0, 0, 0);  // idle
        tbl[5]  = mk(1, 4'b0001, 5, 2, 1, 0, 1,    1, C_LDA, 2'b01, 5, 2, 0);
        tbl[6]  = mk(1, 4'b1010, 4, 6, 0, 0, 0,    1, C_LDA, 2'b01, 5, 2, 0);  // execute stalled: hold
        tbl[7]  = mk(1, 4'b1010, 4, 6, 0, 0, 0,    1, C_LDA, 2'b01, 5, 2, 0);
        tbl[8]  = mk(1, 4'b1010, 4, 6, 0, 0, 0,    1, C_LDA, 2'b01, 5, 2, 0);
        tbl[9]  = mk(1, 4'b1010, 4, 6, 1, 0, 1,    1, C_IMM, 2'b10, 4, 6, 0);  // release
        tbl[10] = mk(1, 4'b1100, 1, 1, 1, 0, 1,    1, C_BAF, 2'b00, 1, 1, 1);  // branch opens window of 2
        tbl[11] = mk(1, 4'b1000, 1, 0, 1, 0, 1,    0, C_NOP, 2'b00, 0, 0, 0);  // dropped
        tbl[12] = mk(1, 4'b1001, 2, 0, 1, 0, 1,    0, C_NOP, 2'b00, 0, 0, 0);  // dropped
        tbl[13] = mk(1, 4'b1011, 3, 0, 1, 0, 1,    1, C_IMM, 2'b11, 3, 0, 0);  // third issues
        tbl[14] = mk(1, 4'b1101, 0, 0, 1, 0, 1,    1, C_BAF, 2'b01, 0, 0, 1);  // branch
        tbl[15] = mk(1, 4'b1000, 6, 0, 0, 0, 0,    1, C_BAF, 2'b01, 0, 0, 0);  // branch held, pulse ends
        tbl[16] = mk(1, 4'b1000, 6, 0, 1, 0, 1,    0, C_NOP, 2'b00, 0, 0, 0);  // dropped, window now 1
        tbl[17] = mk(1, 4'b1010, 7, 2, 1, 1, 1,    0, C_NOP, 2'b00, 0, 0, 0);  // flush kills window + input
        tbl[18] = mk(1, 4'b1001, 7, 2, 1, 0, 1,    1, C_IMM, 2'b01, 7, 2, 0);  // issues right away
        tbl[19] = mk(1, 4'b1100, 0, 0, 1, 0, 1,    1, C_BAF, 2'b00, 0, 0, 1);
        tbl[20] = mk(1, 4'b1111, 0, 0, 1, 0, 1,    0, C_NOP, 2'b00, 0, 0, 0);  // branch in window: dropped
        tbl[21] = mk(1, 4'b1000, 1, 0, 1, 0, 1,    0, C_NOP, 2'b00, 0, 0, 0);  // window not restarted
        tbl[22] = mk(1, 4'b1001, 2, 0, 1, 0, 1,    1, C_IMM, 2'b01, 2, 0, 0);
        tbl[23] = mk(0, 4'b0000, 0, 0, 1, 0, 1,    0, C_NOP, 2'b00, 0, 0, 0);

        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_opcode   = '0;
        i_rd       = '0;
        i_rs       = '0;
        i_ex_ready = 1'b0;
        i_flush    = 1'b0;
        #2;
        check("reset outputs", 32'(all_outs()), 32'd0);
        check("reset ready", 32'(o_ready), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset asserted while a load-use stall is pending
        step("rst_stall_lda", mk(1, 4'b0000, 1, 0, 1, 0, 1, 1, C_LDA, 2'b00, 1, 0, 0));
        @(negedge i_clk);
        i_valid    = 1'b1;
        i_opcode   = 4'b0100;
        i_rd       = 3'd0;
        i_rs       = 3'd1;
        i_ex_ready = 1'b1;
        #1;
        check("rst_stall hazard ready", 32'(o_ready), 32'd0);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("rst_stall async outputs", 32'(all_outs()), 32'd0);
        check("rst_stall async ready", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        #1;
        check("rst_stall held outputs", 32'(all_outs()), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step("rst_stall_sta", mk(1, 4'b0100, 0, 1, 1, 0, 1, 1, C_STA, 2'b00, 0, 1, 0));

        // Reset asserted inside a squash window
        step("rst_sq_baf", mk(1, 4'b1110, 2, 2, 1, 0, 1, 1, C_BAF, 2'b10, 2, 2, 1));
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        i_rst_n = 1'b0;
        #1;
        check("rst_sq async outputs", 32'(all_outs()), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step("rst_sq_imm", mk(1, 4'b1000, 5, 0, 1, 0, 1, 1, C_IMM, 2'b00, 5, 0, 0));
        step("rst_sq_idle", mk(0, 4'b0000, 0, 0, 1, 0, 1, 0, C_NOP, 2'b00, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
